// File: rtl/sbox_pkg.sv
// Shared definitions for the 6-bit S-box screening stage:
// word width, sweep size, word/count types and the sweep FSM states.
package sbox_pkg;
    localparam int SBOX_N    = 6;
    localparam int SBOX_SIZE = 2 ** SBOX_N;

    typedef logic [SBOX_N-1:0] sbox_word_t;
    typedef logic [SBOX_N:0]   sbox_cnt_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SWEEP  = 2'd1,
        REPORT = 2'd2
    } sweep_state_t;
endpackage

// File: rtl/sbox_hit_bitmap.sv
// One bit per possible S-box output value. The bits record which outputs were
// already produced during the current sweep.
module sbox_hit_bitmap
    import sbox_pkg::*;
#(
    parameter int N = SBOX_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         set_en,
    input  logic [N-1:0] addr,
    output logic         hit
);
    localparam int SIZE = 2 ** N;

    logic [SIZE-1:0] bits;

    // hit reflects the bitmap before this cycle's set, so it reads "already produced".
    assign hit = bits[addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bits <= '0;
        end else if (clear) begin
            bits <= '0;
        end else if (set_en) begin
            bits[addr] <= 1'b1;
        end
    end
endmodule

// File: rtl/sbox_sweep_checker.sv
// Sweeps every input through an external combinational S-box and reports
// permutation status, fixed-point count, collision count and first collision.
module sbox_sweep_checker
    import sbox_pkg::*;
#(
    parameter int N = SBOX_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic [N-1:0] sbox_x,
    input  logic [N-1:0] sbox_y,
    output logic         busy,
    output logic         done,
    output logic         is_perm,
    output logic [N:0]   fixed_cnt,
    output logic [N:0]   collision_cnt,
    output logic [N-1:0] first_collision_x
);
    localparam int           SIZE   = 2 ** N;
    localparam logic [N-1:0] K_LAST = N'(SIZE - 1);
    localparam logic [N:0]   CNT_ONE = (N+1)'(1);

    // Handshake: start is taken only while IDLE; busy covers SWEEP and REPORT;
    // done pulses for the single REPORT cycle, and the result outputs are final
    // from that cycle until the next accepted start.
    sweep_state_t state;
    sweep_state_t next_state;

    logic [N-1:0] k;
    logic         accept;
    logic         sweep_en;
    logic         last_k;
    logic         hit;

    assign last_k = (k == K_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = SWEEP;
            SWEEP:   if (last_k) next_state = REPORT;
            REPORT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        accept   = 1'b0;
        sweep_en = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        sbox_x   = '0;
        case (state)
            IDLE:    accept = start;
            SWEEP: begin
                sweep_en = 1'b1;
                busy     = 1'b1;
                sbox_x   = k;
            end
            REPORT: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    sbox_hit_bitmap #(.N(N)) u_bitmap (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (accept),
        .set_en (sweep_en),
        .addr   (sbox_y),
        .hit    (hit)
    );

    // is_perm is settled on the final sweep edge so it is already valid while done is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k                 <= '0;
            fixed_cnt         <= '0;
            collision_cnt     <= '0;
            first_collision_x <= '0;
            is_perm           <= 1'b0;
        end else if (accept) begin
            k                 <= '0;
            fixed_cnt         <= '0;
            collision_cnt     <= '0;
            first_collision_x <= '0;
            is_perm           <= 1'b0;
        end else if (sweep_en) begin
            if (sbox_y == k) begin
                fixed_cnt <= fixed_cnt + CNT_ONE;
            end
            if (hit) begin
                collision_cnt <= collision_cnt + CNT_ONE;
                if (collision_cnt == '0) begin
                    first_collision_x <= k;
                end
            end
            if (last_k) begin
                is_perm <= (collision_cnt == '0) && !hit;
            end else begin
                k <= k + N'(1);
            end
        end
    end
endmodule

// File: tb/tb_sbox_sweep_checker.sv
// Directed bench for sbox_sweep_checker with a bench-side S-box model and a
// queue of expected sweep results compared whenever done pulses.
module tb_sbox_sweep_checker;
    localparam int N = 6;
    localparam int W = 1 + (N + 1) + (N + 1) + N;

    localparam int M_IDENT = 0;
    localparam int M_CONST = 1;
    localparam int M_COMPL = 2;
    localparam int M_POW41 = 3;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [N-1:0] sbox_x;
    logic [N-1:0] sbox_y;
    logic         busy;
    logic         done;
    logic         is_perm;
    logic [N:0]   fixed_cnt;
    logic [N:0]   collision_cnt;
    logic [N-1:0] first_collision_x;

    int mode;
    int checks;
    int failures;
    logic [W-1:0] exp_q[$];

    sbox_sweep_checker #(.N(N)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .sbox_x            (sbox_x),
        .sbox_y            (sbox_y),
        .busy              (busy),
        .done              (done),
        .is_perm           (is_perm),
        .fixed_cnt         (fixed_cnt),
        .collision_cnt     (collision_cnt),
        .first_collision_x (first_collision_x)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // GF(2^6) with x^6 + x + 1
    function automatic logic [5:0] gf_mul(input logic [5:0] a, input logic [5:0] b);
        logic [5:0] p;
        logic [5:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 6; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[5] ? ((aa << 1) ^ 6'h03) : (aa << 1);
        end
        return p;
    endfunction

    function automatic logic [5:0] sbox_fn(input int m, input logic [5:0] x);
        logic [5:0] r;
        case (m)
            M_IDENT: r = x;
            M_CONST: r = 6'h00;
            M_COMPL: r = x ^ 6'h3F;
            default: begin
                r = 6'h01;
                for (int i = 0; i < 41; i++) r = gf_mul(r, x);
                r = r ^ 6'h2B;
            end
        endcase
        return r;
    endfunction

    always_comb sbox_y = sbox_fn(mode, sbox_x);

    // Golden model: histogram for counts, pairwise search for the first collision.
    function automatic logic [W-1:0] model_result(input int m);
        int  hist[64];
        int  fx;
        int  coll;
        int  first;
        bit  found;
        logic [5:0] y;
        for (int v = 0; v < 64; v++) hist[v] = 0;
        fx = 0;
        coll = 0;
        first = 0;
        found = 1'b0;
        for (int x = 0; x < 64; x++) begin
            y = sbox_fn(m, 6'(x));
            if (int'(y) == x) fx++;
            hist[y]++;
        end
        for (int v = 0; v < 64; v++) begin
            if (hist[v] > 1) coll += hist[v] - 1;
        end
        for (int x = 1; x < 64; x++) begin
            for (int x2 = 0; x2 < x; x2++) begin
                if (!found && sbox_fn(m, 6'(x2)) == sbox_fn(m, 6'(x))) begin
                    found = 1'b1;
                    first = x;
                end
            end
        end
        return {(coll == 0), 7'(fx), 7'(coll), 6'(first)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // scoreboard: pop the oldest expectation and compare with the reported results
    task automatic check_results(input string tag);
        logic [W-1:0] e;
        check({tag, "_queue_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, "_is_perm"},   32'(is_perm),           32'(e[W-1]));
            check({tag, "_fixed"},     32'(fixed_cnt),         32'(e[W-2 -: 7]));
            check({tag, "_collision"}, 32'(collision_cnt),     32'(e[W-9 -: 7]));
            check({tag, "_first_x"},   32'(first_collision_x), 32'(e[5:0]));
        end
    endtask

    // driver: called on a negedge while IDLE; returns on the negedge of the done cycle
    task automatic run_sweep(input string tag);
        int n;
        exp_q.push_back(model_result(mode));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
        check({tag, "_first_x_driven"}, 32'(sbox_x), 32'd0);
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_latency"}, 32'(n), 32'd65);
        if (done === 1'b1) check_results(tag);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},      32'(busy),              32'd0);
        check({tag, "_done"},      32'(done),              32'd0);
        check({tag, "_sbox_x"},    32'(sbox_x),            32'd0);
        check({tag, "_is_perm"},   32'(is_perm),           32'd0);
        check({tag, "_fixed"},     32'(fixed_cnt),         32'd0);
        check({tag, "_collision"}, 32'(collision_cnt),     32'd0);
        check({tag, "_first_x"},   32'(first_collision_x), 32'd0);
    endtask

    initial begin
        int n;
        int done_seen;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        mode     = M_IDENT;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // identity, then start during the done cycle must be ignored
        mode = M_IDENT;
        run_sweep("ident");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_at_done_ignored", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        check("results_hold_fixed", 32'(fixed_cnt), 32'd64);
        check("results_hold_perm", 32'(is_perm), 32'd1);

        mode = M_CONST;
        run_sweep("const");
        @(negedge clk);
        mode = M_COMPL;
        run_sweep("compl");
        @(negedge clk);
        mode = M_POW41;
        run_sweep("pow41");
        @(negedge clk);

        // re-pulse start mid-sweep, then reset mid-sweep
        mode  = M_IDENT;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_ignored_x", 32'(sbox_x), 32'd10);
        check("restart_ignored_busy", 32'(busy), 32'd1);
        repeat (19) @(negedge clk);
        check("pre_reset_x", 32'(sbox_x), 32'd29);
        rst_n = 1'b0;
        #1;
        check_all_zero("midsweep_reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        check("no_done_after_abort", 32'(done_seen), 32'd0);
        run_sweep("ident_after_reset");
        @(negedge clk);

        // start held high across two sweeps
        mode = M_IDENT;
        exp_q.push_back(model_result(mode));
        exp_q.push_back(model_result(mode));
        start = 1'b1;
        @(negedge clk);
        n = 1;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("held_first_latency", 32'(n), 32'd65);
        if (done === 1'b1) check_results("held_first");
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 200);
        start = 1'b0;
        check("held_done_spacing", 32'(n), 32'd66);
        if (done === 1'b1) check_results("held_second");
        repeat (2) @(negedge clk);
        check("held_idle_after", 32'(busy), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
